dmem_arbiter: RTL and testbench

Shares the single data-memory port between two requesters.
- Pipeline side: the post-pipe-register load/store path.
- Debug/loader side: a second requester using a req/done handshake.
- CPU has fixed priority; a starvation counter guarantees the debug side a slot, and the whole pipeline freezes (PC and pipe register) for that one cycle.
- Sits between the pipe register outputs and the DataMemory instance in the top level.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arb_starve_ctr.sv | 34 +++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : which requester drives the memory port this cycle
//   *_DEF       : default starvation-limit configuration
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    DBG_ACC  = 2'd1,
    DBG_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  localparam int STARVE_LIMIT_DEF    = 4;
  localparam int STARVE_CNT_BITS_DEF = 3;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating starvation counter for the debug requester.
//   clk_i/reset_i : clock, synchronous active-high reset
//   inc_i         : one contended cycle seen (saturates at STARVE_LIMIT)
//   clr_i         : debug got its slot, restart the count (wins over inc_i)
//   sat_o         : count has reached STARVE_LIMIT
module dmem_arb_starve_ctr import dmem_arb_pkg::*; #(
  parameter int STARVE_LIMIT    = STARVE_LIMIT_DEF,
  parameter int STARVE_CNT_BITS = STARVE_CNT_BITS_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [STARVE_CNT_BITS-1:0] LIMIT = STARVE_CNT_BITS'(STARVE_LIMIT);

  logic [STARVE_CNT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (inc_i && !sat_o)      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign sat_o = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the pipeline (fixed
// priority) and a debug/loader requester using a req/done handshake.
// A starvation counter forces the debug side in after STARVE_LIMIT
// contended cycles; the pipeline is frozen for exactly that grant cycle.
//   clk_i, reset_i          : clock, synchronous active-high reset
//   cpu_*_i / cpu_stall_o   : pipeline request and freeze
//   dbg_*_i / dbg_gnt_o,
//   dbg_done_o, dbg_rdata_o : debug request, grant, done pulse, read data
//   mem_*_o / mem_dOut_i    : DataMemory port (combinational read)
//   stall_count_o           : pipeline-stall performance counter
// Optional: define DMEM_ARB_PERF_EN to build the stall counter; otherwise
// stall_count_o is tied to zero.
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int DBITS               = 32,
  parameter int DMEM_ADDR_BIT_WIDTH = 30,
  parameter int STARVE_LIMIT        = STARVE_LIMIT_DEF,
  parameter int STARVE_CNT_BITS     = STARVE_CNT_BITS_DEF
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           cpu_req_i,
  input  logic                           cpu_wrtEn_i,
  input  logic [DMEM_ADDR_BIT_WIDTH-1:0] cpu_addr_i,
  input  logic [DBITS-1:0]               cpu_dIn_i,
  output logic                           cpu_stall_o,
  input  logic                           dbg_req_i,
  input  logic                           dbg_wrtEn_i,
  input  logic [DMEM_ADDR_BIT_WIDTH-1:0] dbg_addr_i,
  input  logic [DBITS-1:0]               dbg_dIn_i,
  output logic                           dbg_gnt_o,
  output logic                           dbg_done_o,
  output logic [DBITS-1:0]               dbg_rdata_o,
  output logic                           mem_wrtEn_o,
  output logic [DMEM_ADDR_BIT_WIDTH-1:0] mem_addr_o,
  output logic [DBITS-1:0]               mem_dIn_o,
  input  logic [DBITS-1:0]               mem_dOut_i,
  output logic [31:0]                    stall_count_o
);

  arb_state_e       state_q;
  owner_e           own_q;
  logic             done_q;
  logic [DBITS-1:0] rdata_q;
  logic             starve_sat;
  logic             starve_inc, starve_clr;

  // Contention is only counted while the CPU owns the port; a request
  // still high during DBG_RESP is re-evaluated from CPU_OWN.
  assign starve_inc = (state_q == CPU_OWN) && dbg_req_i && cpu_req_i;
  assign starve_clr = (state_q == DBG_ACC);

  dmem_arb_starve_ctr #(
    .STARVE_LIMIT    (STARVE_LIMIT),
    .STARVE_CNT_BITS (STARVE_CNT_BITS)
  ) u_starve (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (starve_inc),
    .clr_i   (starve_clr),
    .sat_o   (starve_sat)
  );

  // own_q and done_q are registered decodes of the next state, so grant,
  // stall and done come straight from flops.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= CPU_OWN;
      own_q   <= OWN_CPU;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        CPU_OWN: begin
          done_q <= 1'b0;
          if (dbg_req_i && (!cpu_req_i || starve_sat)) begin
            state_q <= DBG_ACC;
            own_q   <= OWN_DBG;
          end
        end
        DBG_ACC: begin
          if (!dbg_wrtEn_i) rdata_q <= mem_dOut_i;
          state_q <= DBG_RESP;
          own_q   <= OWN_CPU;
          done_q  <= 1'b1;
        end
        DBG_RESP: begin
          state_q <= CPU_OWN;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= CPU_OWN;
          own_q   <= OWN_CPU;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_gnt_o   = (own_q == OWN_DBG);
  assign cpu_stall_o = (own_q == OWN_DBG);
  assign dbg_done_o  = done_q;
  assign dbg_rdata_o = rdata_q;

  // Write enable is masked by reset so nothing commits on a reset edge,
  // including a debug write caught mid-grant.
  always_comb begin
    if (own_q == OWN_DBG) begin
      mem_wrtEn_o = dbg_wrtEn_i && !reset_i;
      mem_addr_o  = dbg_addr_i;
      mem_dIn_o   = dbg_dIn_i;
    end else begin
      mem_wrtEn_o = cpu_req_i && cpu_wrtEn_i && !reset_i;
      mem_addr_o  = cpu_addr_i;
      mem_dIn_o   = cpu_dIn_i;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cnt_q;

  // Counts grant cycles that actually held back a pipeline memory op.
  always_ff @(posedge clk_i) begin
    if (reset_i)                               stall_cnt_q <= '0;
    else if (state_q == DBG_ACC && cpu_req_i)  stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_count_o = stall_cnt_q;
`else
  assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int LIM = 4;
`ifdef DMEM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wrtEn, cpu_stall;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_dIn;
  logic        dbg_req, dbg_wrtEn, dbg_gnt, dbg_done;
  logic [29:0] dbg_addr;
  logic [31:0] dbg_dIn, dbg_rdata;
  logic        mem_wrtEn;
  logic [29:0] mem_addr;
  logic [31:0] mem_dIn, mem_dOut, stall_count;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk_i(clk), .reset_i(reset),
    .cpu_req_i(cpu_req), .cpu_wrtEn_i(cpu_wrtEn), .cpu_addr_i(cpu_addr),
    .cpu_dIn_i(cpu_dIn), .cpu_stall_o(cpu_stall),
    .dbg_req_i(dbg_req), .dbg_wrtEn_i(dbg_wrtEn), .dbg_addr_i(dbg_addr),
    .dbg_dIn_i(dbg_dIn), .dbg_gnt_o(dbg_gnt), .dbg_done_o(dbg_done),
    .dbg_rdata_o(dbg_rdata),
    .mem_wrtEn_o(mem_wrtEn), .mem_addr_o(mem_addr), .mem_dIn_o(mem_dIn),
    .mem_dOut_i(mem_dOut), .stall_count_o(stall_count)
  );

  // Data memory attached to the DUT port (combinational read).
  logic [31:0] tmem [256];
  assign mem_dOut = tmem[mem_addr[7:0]];
  always @(posedge clk) if (mem_wrtEn) tmem[mem_addr[7:0]] <= mem_dIn;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a debug request gets the next cycle when the CPU is
  // idle, or after LIM contended CPU_OWN cycles; grant cycle then done cycle.
  bit          m_gnt, m_done;
  int          m_wait;
  logic [31:0] m_rdata, m_perf;
  logic [31:0] mmem [256];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt",       {31'd0, dbg_gnt},   {31'd0, m_gnt});
      chk("stall",     {31'd0, cpu_stall}, {31'd0, m_gnt});
      chk("done",      {31'd0, dbg_done},  {31'd0, m_done});
      chk("rdata",     dbg_rdata, m_rdata);
      chk("stall_cnt", stall_count, PERF ? m_perf : 32'd0);
      if (m_gnt) begin
        chk("mem_we",   {31'd0, mem_wrtEn}, {31'd0, dbg_wrtEn & ~reset});
        chk("mem_addr", {2'd0, mem_addr}, {2'd0, dbg_addr});
        chk("mem_din",  mem_dIn, dbg_dIn);
      end else begin
        chk("mem_we",   {31'd0, mem_wrtEn}, {31'd0, cpu_req & cpu_wrtEn & ~reset});
        chk("mem_addr", {2'd0, mem_addr}, {2'd0, cpu_addr});
        chk("mem_din",  mem_dIn, cpu_dIn);
      end
      // advance model across the coming edge
      if (reset) begin
        m_gnt = 0; m_done = 0; m_wait = 0; m_rdata = 0; m_perf = 0;
      end else if (m_gnt) begin
        if (dbg_wrtEn) mmem[dbg_addr[7:0]] = dbg_dIn;
        else           m_rdata = mmem[dbg_addr[7:0]];
        if (cpu_req) m_perf = m_perf + 1;
        m_gnt = 0; m_done = 1; m_wait = 0;
      end else begin
        if (cpu_req && cpu_wrtEn) mmem[cpu_addr[7:0]] = cpu_dIn;
        if (m_done) m_done = 0;
        else begin
          m_gnt = dbg_req && (!cpu_req || m_wait == LIM);
          if (dbg_req && cpu_req && m_wait < LIM) m_wait++;
        end
      end
    end
  end

  // Present a debug request at the next cycle and check grant latency,
  // grant-cycle port contents and the done pulse.
  task automatic do_dbg(input bit wr, input logic [29:0] a, input logic [31:0] d,
                        input int exp_lat, input string nm);
    int k;
    @(posedge clk); #1;
    dbg_req = 1; dbg_wrtEn = wr; dbg_addr = a; dbg_dIn = d;
    k = 0;
    @(negedge clk);
    while (!dbg_gnt && k < 30) begin
      @(posedge clk); #1; k++; @(negedge clk);
    end
    chk({nm, "_lat"}, k, exp_lat);
    chk({nm, "_gstall"}, {31'd0, cpu_stall}, 32'd1);
    chk({nm, "_gwe"}, {31'd0, mem_wrtEn}, {31'd0, wr});
    chk({nm, "_gaddr"}, {2'd0, mem_addr}, {2'd0, a});
    @(posedge clk); #1; dbg_req = 0;
    @(negedge clk);
    chk({nm, "_done"}, {31'd0, dbg_done}, 32'd1);
    chk({nm, "_dstall"}, {31'd0, cpu_stall}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin tmem[i] = 0; mmem[i] = 0; end
    m_gnt = 0; m_done = 0; m_wait = 0; m_rdata = 0; m_perf = 0;
    dbg_req = 0; dbg_wrtEn = 0; dbg_addr = 0; dbg_dIn = 0;
    // T1: reset with a pending CPU store
    reset = 1; cpu_req = 1; cpu_wrtEn = 1; cpu_addr = 30'h4; cpu_dIn = 32'h1234;
    @(negedge clk); chk("rst_we0", {31'd0, mem_wrtEn}, 32'd0);
    @(posedge clk); #1; chk_en = 1;
    @(negedge clk); chk("rst_we1", {31'd0, mem_wrtEn}, 32'd0);
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    chk("post_stall", {31'd0, cpu_stall}, 32'd0);
    chk("post_done",  {31'd0, dbg_done}, 32'd0);
    chk("post_rdata", dbg_rdata, 32'd0);
    chk("post_we",    {31'd0, mem_wrtEn}, 32'd1);
    chk("post_addr",  {2'd0, mem_addr}, 32'h4);

    // T2: idle CPU write then read-back
    @(posedge clk); #1; cpu_req = 0; cpu_wrtEn = 0;
    do_dbg(1, 30'h10, 32'hDEADBEEF, 1, "t2w");
    do_dbg(0, 30'h10, 32'h0, 1, "t2r");
    chk("t2_rdata", dbg_rdata, 32'hDEADBEEF);

    // T3: contended read forced in after the starvation limit
    cpu_req = 1;
    do_dbg(0, 30'h10, 32'h0, LIM + 1, "t3");

    // T5: request held through DBG_RESP -> two back-to-back reads
    @(posedge clk); #1; cpu_req = 0;
    dbg_req = 1; dbg_wrtEn = 0; dbg_addr = 30'h10;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 5) dbg_req = 0;
      @(negedge clk);
      chk("t5_gnt",   {31'd0, dbg_gnt},   {31'd0, 1'(c == 1 || c == 4)});
      chk("t5_done",  {31'd0, dbg_done},  {31'd0, 1'(c == 2 || c == 5)});
      chk("t5_stall", {31'd0, cpu_stall}, {31'd0, 1'(c == 1 || c == 4)});
    end

    // T4: reset during the grant cycle of a write
    @(posedge clk); #1;
    dbg_req = 1; dbg_wrtEn = 1; dbg_addr = 30'h20; dbg_dIn = 32'h55;
    @(posedge clk); #1; reset = 1;
    @(negedge clk);
    chk("t4_gnt", {31'd0, dbg_gnt}, 32'd1);
    chk("t4_we",  {31'd0, mem_wrtEn}, 32'd0);
    @(posedge clk); #1; reset = 0; dbg_req = 0;
    @(negedge clk);
    chk("t4_done", {31'd0, dbg_done}, 32'd0);
    chk("t4_gnt2", {31'd0, dbg_gnt}, 32'd0);
    chk("t4_mem",  tmem[8'h20], 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_done2", {31'd0, dbg_done}, 32'd0);

    // T6: two forced accesses with CPU busy
    cpu_req = 1;
    do_dbg(0, 30'h10, 32'h0, LIM + 1, "t6a");
    do_dbg(1, 30'h11, 32'hA5A5, LIM + 1, "t6b");
    chk("t6_cnt", stall_count, PERF ? 32'd2 : 32'd0);

    // Random traffic; debug holds its request until done.
    repeat (3000) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 299) == 0);
      cpu_req   = ($urandom_range(0, 9) < 7);
      cpu_wrtEn = 1'($urandom);
      cpu_addr  = 30'($urandom);
      cpu_dIn   = $urandom;
      if (!(dbg_req && !dbg_done)) begin
        dbg_req   = ($urandom_range(0, 2) == 0);
        dbg_wrtEn = 1'($urandom);
        dbg_addr  = 30'($urandom_range(0, 31));
        dbg_dIn   = $urandom;
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
